// File: rtl/servo_pwm_gen_pkg.sv
// Shared state encoding, default timing constants and width helpers for the
// servo PWM generator and its width-mapping sub-module.
package servo_pwm_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam int DEF_WIDTH      = 12;
  localparam int DEF_PERIOD_CYC = 1000000;
  localparam int DEF_CENTER_CYC = 75000;
  localparam int DEF_SCALE      = 12;
  localparam int DEF_MIN_CYC    = 50000;
  localparam int DEF_MAX_CYC    = 100000;

  // Counter must hold both the frame position and the largest pulse width.
  function automatic int cnt_bits(input int period, input int maxCyc);
    int span;
    span = (period > maxCyc + 1) ? period : maxCyc + 1;
    return (span <= 2) ? 1 : $clog2(span);
  endfunction

  function automatic int ext_bits(input int cntW, input int cmdW, input int scale);
    return cntW + cmdW + 1 + $clog2(scale + 1);
  endfunction

endpackage

// File: rtl/servo_width_map.sv
// Combinational map from a signed servo command to a clamped pulse width:
// CENTER_CYC + cmd*SCALE, limited to [MIN_CYC, MAX_CYC].
module servo_width_map
  import servo_pwm_gen_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int CW         = 20,
  parameter int CENTER_CYC = DEF_CENTER_CYC,
  parameter int SCALE      = DEF_SCALE,
  parameter int MIN_CYC    = DEF_MIN_CYC,
  parameter int MAX_CYC    = DEF_MAX_CYC
) (
  input  logic signed [WIDTH-1:0] cmd_i,
  output logic        [CW-1:0]    width_o
);

  // Wide enough that the product and the offset can never overflow.
  localparam int EW = ext_bits(CW, WIDTH, SCALE);

  localparam logic signed [EW-1:0] CenterS = EW'(CENTER_CYC);
  localparam logic signed [EW-1:0] ScaleS  = EW'(SCALE);
  localparam logic signed [EW-1:0] MinS    = EW'(MIN_CYC);
  localparam logic signed [EW-1:0] MaxS    = EW'(MAX_CYC);

  logic signed [EW-1:0] cmdExt;
  logic signed [EW-1:0] raw;

  assign cmdExt = EW'(cmd_i);

  always_comb begin
    raw = CenterS + cmdExt * ScaleS;
    if (raw < MinS) begin
      width_o = CW'(MIN_CYC);
    end else if (raw > MaxS) begin
      width_o = CW'(MAX_CYC);
    end else begin
      width_o = raw[CW-1:0];
    end
  end

endmodule

// File: rtl/servo_pwm_gen.sv
// Servo PWM generator: captures controller commands on dataf_i rising edges,
// converts them to pulse widths and applies them only at frame boundaries.
module servo_pwm_gen
  import servo_pwm_gen_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int PERIOD_CYC = DEF_PERIOD_CYC,
  parameter int CENTER_CYC = DEF_CENTER_CYC,
  parameter int SCALE      = DEF_SCALE,
  parameter int MIN_CYC    = DEF_MIN_CYC,
  parameter int MAX_CYC    = DEF_MAX_CYC
) (
  input  logic                    clk_i,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] servo_i,
  input  logic                    dataf_i,
  output logic                    pwm_o,
  output logic                    ack_o,
  output logic                    frame_o
);

  localparam int            CW      = cnt_bits(PERIOD_CYC, MAX_CYC);
  localparam logic [CW-1:0] LastCnt = CW'(PERIOD_CYC - 1);

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    dataf_q;
  logic signed [WIDTH-1:0] cmd_q, cmd_d;
  logic [CW-1:0]           pendWidth_q, pendWidth_d;
  logic                    pendValid_q, pendValid_d;
  logic [CW-1:0]           actWidth_q, actWidth_d;
  logic                    actValid_q, actValid_d;
  logic                    pwm_q, pwm_d;
  logic                    ack_q, ack_d;
  logic                    frame_q, frame_d;

  logic [CW-1:0]           convWidth;
  logic                    edgeSeen;
  logic                    wrapNow;
  logic                    loadNow;
  logic                    runNow;

  servo_width_map #(
    .WIDTH      (WIDTH),
    .CW         (CW),
    .CENTER_CYC (CENTER_CYC),
    .SCALE      (SCALE),
    .MIN_CYC    (MIN_CYC),
    .MAX_CYC    (MAX_CYC)
  ) uWidthMap (
    .cmd_i   (cmd_q),
    .width_o (convWidth)
  );

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      dataf_q     <= 1'b0;
      cmd_q       <= '0;
      pendWidth_q <= '0;
      pendValid_q <= 1'b0;
      actWidth_q  <= '0;
      actValid_q  <= 1'b0;
      pwm_q       <= 1'b0;
      ack_q       <= 1'b0;
      frame_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dataf_q     <= dataf_i;
      cmd_q       <= cmd_d;
      pendWidth_q <= pendWidth_d;
      pendValid_q <= pendValid_d;
      actWidth_q  <= actWidth_d;
      actValid_q  <= actValid_d;
      pwm_q       <= pwm_d;
      ack_q       <= ack_d;
      frame_q     <= frame_d;
    end
  end

  always_comb begin
    edgeSeen = dataf_i & ~dataf_q;
    wrapNow  = (cnt_q == LastCnt);
    loadNow  = (cnt_q == '0) && pendValid_q;

    cnt_d = wrapNow ? '0 : cnt_q + CW'(1);
    cmd_d = edgeSeen ? servo_i : cmd_q;

    // A conversion finishing on a boundary cycle overrides the clear, so it
    // waits for the following frame instead of being lost.
    pendWidth_d = pendWidth_q;
    pendValid_d = pendValid_q;
    if (loadNow) begin
      pendValid_d = 1'b0;
    end
    if (state_q == ST_CONV) begin
      pendWidth_d = convWidth;
      pendValid_d = 1'b1;
    end

    actWidth_d = loadNow ? pendWidth_q : actWidth_q;
    actValid_d = actValid_q | loadNow;

    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (edgeSeen) begin
          state_d = ST_CONV;
        end else if (loadNow) begin
          state_d = ST_RUN;
        end
      end
      ST_CONV: state_d = actValid_d ? ST_RUN : ST_IDLE;
      ST_RUN: begin
        if (edgeSeen) begin
          state_d = ST_CONV;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Width in force for this frame includes one being loaded right now, so
    // the first frame after a load gets its full pulse.
    runNow  = (state_q != ST_IDLE) || loadNow;
    pwm_d   = runNow && actValid_d && (cnt_q < actWidth_d);
    frame_d = wrapNow;
    ack_d   = wrapNow && pendValid_d;
  end

  assign pwm_o   = pwm_q;
  assign ack_o   = ack_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Self-checking bench for servo_pwm_gen: a cycle-indexed scoreboard plus
// directed scenarios with hand-computed pulse widths.
module tb_servo_pwm_gen;

  localparam int W      = 12;
  localparam int P      = 200;
  localparam int CENTER = 100;
  localparam int SCALE  = 1;
  localparam int MINC   = 50;
  localparam int MAXC   = 150;

  logic                clk_i   = 1'b0;
  logic                reset   = 1'b1;
  logic                dataf_i = 1'b0;
  logic signed [W-1:0] servo_i = '0;
  logic                pwm_o;
  logic                ack_o;
  logic                frame_o;

  int vectors     = 0;
  int miscompares = 0;
  int posCnt      = 0;
  int acksSeen    = 0;
  int wEff        = 0;

  typedef struct {
    int at;
    int w;
  } apply_t;
  apply_t applyQ[$];

  always #5 clk_i = ~clk_i;

  servo_pwm_gen #(
    .WIDTH      (W),
    .PERIOD_CYC (P),
    .CENTER_CYC (CENTER),
    .SCALE      (SCALE),
    .MIN_CYC    (MINC),
    .MAX_CYC    (MAXC)
  ) dut (
    .clk_i   (clk_i),
    .reset   (reset),
    .servo_i (servo_i),
    .dataf_i (dataf_i),
    .pwm_o   (pwm_o),
    .ack_o   (ack_o),
    .frame_o (frame_o)
  );

  function automatic int modelWidth(input int v);
    int r;
    r = CENTER + v * SCALE;
    if (r < MINC) r = MINC;
    else if (r > MAXC) r = MAXC;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Cycles since reset release: cycle k lies between posedge k and k+1.
  initial begin
    forever begin
      @(posedge clk_i);
      if (reset) posCnt = 0;
      else posCnt++;
    end
  end

  // Scoreboard: a command raised in cycle j takes effect at the first frame
  // start at or after j+2; pwm_o in cycle k reflects position (k-1) mod P.
  initial begin
    int k;
    logic expPwm, expAck, expFrame;
    forever begin
      @(negedge clk_i);
      if (reset) begin
        checkOutput("pwm_in_reset", pwm_o, 0);
        checkOutput("ack_in_reset", ack_o, 0);
        checkOutput("frame_in_reset", frame_o, 0);
        wEff = 0;
        applyQ.delete();
      end else begin
        k        = posCnt;
        expPwm   = (k >= 1) && (wEff > ((k - 1) % P));
        expAck   = 1'b0;
        if (applyQ.size() > 0 && applyQ[0].at == k) begin
          expAck = 1'b1;
          wEff   = applyQ[0].w;
          void'(applyQ.pop_front());
        end
        expFrame = (k > 0) && (k % P == 0);
        checkOutput("pwm", pwm_o, expPwm);
        checkOutput("ack", ack_o, expAck);
        checkOutput("frame", frame_o, expFrame);
      end
    end
  end

  task automatic tickTo(input int pos);
    do begin
      @(posedge clk_i);
      #1;
    end while (posCnt % P != pos);
  endtask

  task automatic applyStimulus(input int v);
    apply_t e;
    servo_i = W'(v);
    dataf_i = 1'b1;
    e.at    = ((posCnt + 2 + P - 1) / P) * P;
    e.w     = modelWidth(v);
    if (applyQ.size() > 0 && applyQ[applyQ.size()-1].at == e.at) void'(applyQ.pop_back());
    applyQ.push_back(e);
    @(posedge clk_i);
    #1;
    dataf_i = 1'b0;
  endtask

  task automatic waitFrameStart();
    int n;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
      if (ack_o === 1'b1) acksSeen++;
    end while (frame_o !== 1'b1 && n < 3 * P);
    if (frame_o !== 1'b1) checkOutput("frame_timeout", frame_o, 1);
  endtask

  task automatic measurePulse(output int hi);
    hi = 0;
    repeat (P) begin
      @(negedge clk_i);
      if (pwm_o === 1'b1) hi++;
      if (ack_o === 1'b1) acksSeen++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int hi, frames;

    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("reset_pwm", pwm_o, 0);
    checkOutput("reset_frame", frame_o, 0);
    reset = 1'b0;

    // Idle: three frames, no pulse, no ack.
    hi = 0; frames = 0; acksSeen = 0;
    repeat (3 * P + 1) begin
      @(negedge clk_i);
      if (pwm_o === 1'b1) hi++;
      if (frame_o === 1'b1) frames++;
      if (ack_o === 1'b1) acksSeen++;
    end
    checkOutput("idle_frames", frames, 3);
    checkOutput("idle_pwm_high", hi, 0);
    checkOutput("idle_acks", acksSeen, 0);

    // +20 mid-frame: 120-cycle pulses from the next frame on.
    tickTo(100);
    applyStimulus(20);
    waitFrameStart();
    checkOutput("ack_first_boundary", ack_o, 1);
    measurePulse(hi);
    checkOutput("width_plus20_a", hi, 120);
    measurePulse(hi);
    checkOutput("width_plus20_b", hi, 120);

    // Clamping at both ends.
    tickTo(100);
    applyStimulus(100);
    waitFrameStart();
    measurePulse(hi);
    checkOutput("width_clamp_max", hi, 150);
    tickTo(100);
    applyStimulus(-2048);
    waitFrameStart();
    measurePulse(hi);
    checkOutput("width_clamp_min", hi, 50);

    // Two commands in one frame: the later one wins, a single ack.
    acksSeen = 0;
    tickTo(50);
    applyStimulus(-10);
    tickTo(100);
    applyStimulus(30);
    waitFrameStart();
    measurePulse(hi);
    checkOutput("width_last_wins", hi, 130);
    checkOutput("acks_last_wins", acksSeen, 1);

    // Edge on the boundary cycle applies one frame later.
    tickTo(100);
    applyStimulus(20);
    waitFrameStart();
    measurePulse(hi);
    checkOutput("width_before_boundary_edge", hi, 120);
    tickTo(0);
    applyStimulus(50);
    measurePulse(hi);
    checkOutput("width_boundary_edge_frame", hi, 120);
    checkOutput("ack_boundary_edge_next", ack_o, 1);
    measurePulse(hi);
    checkOutput("width_after_boundary_edge", hi, 150);

    // Conversion landing on the boundary cycle is deferred one frame.
    tickTo(P - 1);
    applyStimulus(-20);
    measurePulse(hi);
    checkOutput("width_deferred_conv_old", hi, 150);
    waitFrameStart();
    checkOutput("ack_deferred_conv", ack_o, 1);
    measurePulse(hi);
    checkOutput("width_deferred_conv_new", hi, 80);

    // Reset in the middle of a 120-cycle pulse.
    tickTo(100);
    applyStimulus(20);
    waitFrameStart();
    repeat (60) begin
      @(posedge clk_i);
      #1;
    end
    checkOutput("pwm_mid_pulse", pwm_o, 1);
    reset = 1'b1;
    #1;
    checkOutput("pwm_reset_immediate", pwm_o, 0);
    checkOutput("ack_reset_immediate", ack_o, 0);
    checkOutput("frame_reset_immediate", frame_o, 0);
    repeat (2) @(posedge clk_i);
    #1;
    reset = 1'b0;
    hi = 0; acksSeen = 0;
    repeat (2 * P + 1) begin
      @(negedge clk_i);
      if (pwm_o === 1'b1) hi++;
      if (ack_o === 1'b1) acksSeen++;
    end
    checkOutput("post_reset_pwm_high", hi, 0);
    checkOutput("post_reset_acks", acksSeen, 0);
    tickTo(100);
    applyStimulus(-30);
    waitFrameStart();
    measurePulse(hi);
    checkOutput("width_after_reset_cmd", hi, 70);

    @(negedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/servo_pwm_gen.md
SERVO_PWM_GEN -- requirements
Module: servo_pwm_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 12, command word width.
REQ-002 SHALL have parameter PERIOD_CYC, default 1000000, PWM frame length in clk_i cycles (20 ms at 50 MHz).
REQ-003 SHALL have parameter CENTER_CYC, default 75000, pulse width for command 0.
REQ-004 SHALL have parameter SCALE, default 12, cycles added per command LSB.
REQ-005 SHALL have parameter MIN_CYC, default 50000, minimum pulse width.
REQ-006 SHALL have parameter MAX_CYC, default 100000, maximum pulse width.
REQ-007 SHALL have port clk_i, input, 1, single clock.
REQ-008 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-009 SHALL have port servo_i, input, WIDTH, signed two's-complement controller output.
REQ-010 SHALL have port dataf_i, input, 1, data-valid from controller; rising edge marks new servo_i.
REQ-011 SHALL have port pwm_o, output, 1, registered servo PWM drive.
REQ-012 SHALL have port ack_o, output, 1, one-cycle pulse when a new width becomes active.
REQ-013 SHALL have port frame_o, output, 1, one-cycle pulse on the first cycle of each frame.

Function
REQ-014 SHALL detect the dataf_i rising edge with a registered copy of dataf_i; a level held high counts once.
REQ-015 On the edge cycle, SHALL capture servo_i into a command register; the new width SHALL be valid one cycle later (conversion state).
REQ-016 Width SHALL be CENTER_CYC + servo_i*SCALE in signed arithmetic of at least counter width + WIDTH + 1 bits, with no intermediate overflow.
REQ-017 SHALL clamp the width to MIN_CYC when below it and to MAX_CYC when above it.
REQ-018 Converted width SHALL go to a pending register and set a pending flag.
REQ-019 Free-running frame counter SHALL count 0..PERIOD_CYC-1 and wrap to 0; frame_o=1 when counter==0.
REQ-020 When counter==0 and pending flag is set, active width SHALL load from pending, pending flag SHALL clear, and ack_o SHALL pulse that cycle.
REQ-021 pwm_o SHALL be 1 when counter < active width and state is RUN, else 0, and SHALL be registered (one cycle after the counter).
REQ-022 FSM states: IDLE (no command since reset, pwm_o=0), CONV (one cycle, width compute), RUN.
REQ-023 Transitions: IDLE->CONV on edge; CONV->RUN if active valid, else CONV->IDLE with pending set; IDLE with pending set->RUN at the next counter==0; RUN->CONV on edge; CONV->RUN.
REQ-024 pwm_o SHALL keep its current pulse through CONV; the active width changes only at a frame boundary, never mid-pulse.
REQ-025 Several edges within one frame: last converted value wins; earlier pending values are discarded silently.
REQ-026 An edge on the counter==0 cycle SHALL NOT affect that boundary; it applies at the next frame.
REQ-027 A conversion finishing on the counter==0 cycle SHALL be deferred to the next frame.

Reset
REQ-028 Reset asserted SHALL immediately force pwm_o=0, ack_o=0, frame_o=0, counter=0, state=IDLE, and pending flag, command, pending and active registers to 0.
REQ-029 Reset asserted mid-pulse SHALL end the pulse at once; after release, pwm_o stays 0 until a new command is captured and reaches a boundary.

Structure
REQ-030 A shared package SHALL hold the state encoding (IDLE, CONV, RUN) and default timing constants (PERIOD_CYC, CENTER_CYC, SCALE, MIN_CYC, MAX_CYC).
REQ-031 Width compute and clamp SHALL be a combinational sub-module, servo_width_map; counter, FSM and registers stay in servo_pwm_gen.

Verification (PERIOD_CYC=200, CENTER_CYC=100, SCALE=1, MIN_CYC=50, MAX_CYC=150)
REQ-032 Reset release, no dataf_i for 3 frames -> pwm_o constantly 0; frame_o pulses every 200 cycles; ack_o never pulses.
REQ-033 servo_i=+20 with a one-cycle dataf_i pulse mid-frame -> ack_o at the next counter==0; pwm_o high exactly 120 cycles per frame thereafter.
REQ-034 servo_i=+100, then servo_i=-2048 -> 150-cycle pulse, then 50-cycle pulse (clamps).
REQ-035 Edges with -10 then +30 in the same frame -> next frame pulse is 130 cycles; -10 is never applied; one ack_o.
REQ-036 Edge coincident with counter==0 while a 120-cycle width is active -> that frame stays 120; new width appears one frame later.
REQ-037 Reset asserted at cycle 60 of a 120-cycle pulse -> pwm_o=0 in the same cycle; after release pwm_o stays 0 until a new command's boundary.
